// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
// The FSM state enum and operation-mode encodings live here so the top and bench agree.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_fa_cell.sv
// One-bit combinational full adder; the only arithmetic element of the serial datapath.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract: one result bit per clock, LSB first, WIDTH clocks per operation.
// Subtraction feeds the adder inverted B with the carry flop preset to 1.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             carry_out,
    output logic             overflow
);

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             c_q;
    logic             mode_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] s_q;
    logic             carry_out_q;
    logic             overflow_q;

    logic             sum_bit;
    logic             cout_bit;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;

    fa_cell u_fa (
        .a    (a_q[0]),
        .b    (b_q[0] ^ mode_q),
        .cin  (c_q),
        .sum  (sum_bit),
        .cout (cout_bit)
    );

    // A doubles as the result register: sum bits enter at the top as operand bits leave.
    assign a_d = {sum_bit, a_q[WIDTH-1:1]};
    assign b_d = {1'b0, b_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= 1'b0;
            mode_q      <= MODE_ADD;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            s_q         <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        c_q     <= (mode == MODE_SUB);
                        mode_q  <= mode;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_q   <= a_d;
                    b_q   <= b_d;
                    c_q   <= cout_bit;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        // c_q is the carry into the MSB, cout_bit the carry out of it.
                        s_q         <= a_d;
                        carry_out_q <= cout_bit;
                        overflow_q  <= c_q ^ cout_bit;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign s         = s_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock; all state changes on this edge.
REQ-003 clear  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 mode  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start.
REQ-006 a  input  WIDTH  operand A; sampled with start.
REQ-007 b  input  WIDTH  operand B; sampled with start.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse when s, carry_out and overflow are updated.
REQ-010 s  output  WIDTH  registered result; holds until next completion.
REQ-011 carry_out  output  1  final carry; in subtract mode 1 = no borrow.
REQ-012 overflow  output  1  two's-complement signed overflow of the last operation.

Function
REQ-013 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-014 IDLE to SHIFT: start=1 at an edge; the same edge loads shift reg A<=a, shift reg B<=b, carry flop<=mode, bit counter<=0, latched mode<=mode.
REQ-015 SHIFT: each edge SHALL process one bit, LSB first: bit = A[0] ^ (B[0]^mode_l) ^ c; c <= majority(A[0], B[0]^mode_l, c); A shifts right with bit entering A[WIDTH-1]; B shifts right.
REQ-016 SHIFT SHALL last exactly WIDTH edges; on the WIDTH-th edge, go to DONE and load s<=final A, carry_out<=final carry, overflow<=carry into MSB XOR carry out of MSB.
REQ-017 done SHALL be high only in DONE, for exactly one cycle, first visible after the WIDTH-th shift edge (WIDTH edges after the start edge); DONE to IDLE unconditionally.
REQ-018 busy SHALL be high in SHIFT and DONE, low in IDLE.
REQ-019 start, a, b, mode changes SHALL be ignored in SHIFT and DONE; the operation in flight is unaffected.
REQ-020 Back-to-back: start held high SHALL launch a new operation on the first edge in IDLE after DONE (period WIDTH+2 cycles).
REQ-021 Arithmetic SHALL be modulo 2^WIDTH; subtraction SHALL use inverted B with carry-in 1.

Reset
REQ-022 clear=0 SHALL immediately force state IDLE, busy=0, done=0, s=0, carry_out=0, overflow=0, counter=0, internal shift regs and carry flop=0.
REQ-023 Reset mid-operation SHALL abandon it with no done pulse; s keeps reset value 0.
REQ-024 The first start SHALL be accepted on the first rising edge after clear deasserts.

Structure
REQ-025 Shared package serial_addsub_pkg SHALL hold the state enum typedef and MODE_ADD/MODE_SUB constants.
REQ-026 Counter width SHALL be $clog2(WIDTH+1).
REQ-027 One sub-module SHALL be used: fa_cell, a combinational one-bit full adder (a, b, cin -> sum, cout), instantiated once.

Verification (WIDTH=8)
REQ-028 Add 0x35+0x1A -> after 8 edges done=1, s=0x4F, carry_out=0, overflow=0.
REQ-029 Sub 0x05-0x07 -> s=0xFE, carry_out=0, overflow=0; sub 0x80-0x01 -> s=0x7F, carry_out=1, overflow=1.
REQ-030 Add 0x7F+0x01 -> s=0x80, overflow=1, carry_out=0; add 0xFF+0x01 -> s=0x00, carry_out=1, overflow=0.
REQ-031 Pulse start with a=0x10,b=0x01, then pulse start with a=0xAA at shift cycle 3 -> single done, s=0x11; second start ignored.
REQ-032 Assert clear at shift cycle 4 -> busy=0, s=0 immediately; no done; new start afterwards completes normally.
REQ-033 start held high for 30 cycles -> done pulses every 10 cycles, busy low exactly one cycle between operations.
